sub_result_stage: RTL

Registered output stage placed directly downstream of the 4-bit ripple subtractor. It captures the subtractor's difference and borrow-out, together with the original operands, under a valid/ready handshake. It derives status flags (zero, negative, signed overflow) and holds results in a 2-entry skid buffer, so full throughput is sustained under backpressure and output timing is decoupled from the combinational ripple chain.

---
 rtl/sub_pkg.sv | 20 ++
 rtl/sub_flag_gen.sv | 22 ++
 rtl/sub_result_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types for the subtractor result stage: default width, FSM states, result flags.
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } sub_state_t;

  // Status flags stored alongside each captured difference
  typedef struct packed {
    logic borrow;
    logic zero;
    logic neg;
    logic ovf;
  } sub_flags_t;

endpackage

// File: rtl/sub_flag_gen.sv
// Combinational status-flag derivation from the subtractor operands and its difference.
module sub_flag_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] diff,
  output logic             zero_c,
  output logic             neg_c,
  output logic             ovf_c
);

  localparam int unsigned MSB = WIDTH - 1;

  // Overflow only when operand signs differ and the result sign departs from A
  always_comb begin
    zero_c = (diff == '0);
    neg_c  = diff[MSB];
    ovf_c  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  end

endmodule

// File: rtl/sub_result_stage.sv
// Registered 2-entry skid output stage for the ripple subtractor with derived status flags.
// Optional borrow-event counter enabled by defining SUB_STATS_EN.
module sub_result_stage
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_diff,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_borrow_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    sub_flags_t       flags;
  } entry_t;

  sub_state_t state, state_nx;
  entry_t     m_q, s_q, in_entry;
  logic       load_m, load_s, m_from_s;
  logic       in_fire, out_fire;
  logic       zero_c, neg_c, ovf_c;

  sub_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a      (in_a),
    .b      (in_b),
    .diff   (in_diff),
    .zero_c (zero_c),
    .neg_c  (neg_c),
    .ovf_c  (ovf_c)
  );

  always_comb begin
    in_entry              = '0;
    in_entry.diff         = in_diff;
    in_entry.flags.borrow = in_borrow;
    in_entry.flags.zero   = zero_c;
    in_entry.flags.neg    = neg_c;
    in_entry.flags.ovf    = ovf_c;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register; handshake flags are re-registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != TWO);
      out_valid <= (state_nx != EMPTY);
    end
  end

  always_comb begin
    state_nx = state;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_m   = 1'b1;
          state_nx = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_m = 1'b1;
        end else if (in_fire) begin
          load_s   = 1'b1;
          state_nx = TWO;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          m_from_s = 1'b1;
          state_nx = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m) begin
        m_q <= in_entry;
      end else if (m_from_s) begin
        m_q <= s_q;
      end
      if (load_s) begin
        s_q <= in_entry;
      end
    end
  end

  assign out_diff   = m_q.diff;
  assign out_borrow = m_q.flags.borrow;
  assign out_zero   = m_q.flags.zero;
  assign out_neg    = m_q.flags.neg;
  assign out_ovf    = m_q.flags.ovf;

`ifdef SUB_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of borrow results leaving the stage; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stat_clr) begin
      cnt_q <= '0;
    end else if (out_fire && m_q.flags.borrow && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stat_borrow_cnt = cnt_q;
`else
  logic stat_clr_unused;

  assign stat_clr_unused = stat_clr;
  assign stat_borrow_cnt = '0;
`endif

endmodule
